// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared scheduler state encoding and row geometry helper
package pmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    TGT  = 2'd2
  } sched_state_t;

  function automatic int unsigned row_beats(input int unsigned row_size,
                                            input int unsigned beat_size);
    return row_size / beat_size;
  endfunction

endpackage

// File: rtl/phase_row_sched_if.sv
// rtl/phase_row_sched_if.sv - stream bundle shared by the two row inputs and the output
interface phase_row_sched_if #(
  parameter int unsigned DW = 128
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - single output register stage; load says the stage can take a beat
module axis_reg_slice #(
  parameter int unsigned DW = 128
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_user,
  output logic          load,
  phase_row_sched_if.master m_axis
);

  // The stage is free when empty or when its current beat leaves this cycle.
  assign load = !m_axis.tvalid || m_axis.tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= in_valid;
      if (in_valid) begin
        m_axis.tdata <= in_data;
        m_axis.tlast <= in_last;
        m_axis.tuser <= in_user;
      end
    end
  end

endmodule

// File: rtl/phase_row_sched.sv
// rtl/phase_row_sched.sv - alternates reference and target rows onto one output stream
module phase_row_sched
  import pmp_pkg::*;
#(
  parameter int unsigned ROW_SIZE   = 1280,
  parameter int unsigned BEAT_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_NUM    = 720,
  localparam int unsigned RIW       = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           en,
  phase_row_sched_if.slave  s0_axis,
  phase_row_sched_if.slave  s1_axis,
  phase_row_sched_if.master m_axis,
  output logic [RIW-1:0] row_idx,
  output logic           frame_done,
  output logic           err_len
);

  localparam int unsigned DW        = BEAT_SIZE * DATA_WIDTH;
  localparam int unsigned ROW_BEATS = row_beats(ROW_SIZE, BEAT_SIZE);
  localparam int unsigned BCW       = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(ROW_BEATS - 1);
  localparam logic [RIW-1:0] LAST_ROW  = RIW'(ROW_NUM - 1);

  sched_state_t   state, state_nx;
  logic [BCW-1:0] beat_cnt;
  logic           load;
  logic           in_valid;
  logic           in_last;
  logic [DW-1:0]  in_data;
  logic           accept;
  logic           cnt_last;

  assign s0_axis.tready = (state == REF) && load;
  assign s1_axis.tready = (state == TGT) && load;
  assign cnt_last       = (beat_cnt == LAST_BEAT);
  assign accept         = in_valid && load;

  always_comb begin
    in_valid = 1'b0;
    in_data  = s0_axis.tdata;
    in_last  = s0_axis.tlast;
    if (state == REF) begin
      in_valid = s0_axis.tvalid;
    end else if (state == TGT) begin
      in_valid = s1_axis.tvalid;
      in_data  = s1_axis.tdata;
      in_last  = s1_axis.tlast;
    end
  end

  // Row boundaries come only from the beat counter; en is sampled at row ends.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = REF;
      REF:     if (accept && cnt_last) state_nx = TGT;
      TGT:     if (accept && cnt_last) state_nx = en ? REF : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      row_idx    <= '0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      if (accept) begin
        beat_cnt <= cnt_last ? '0 : beat_cnt + 1'b1;
        err_len  <= (in_last != cnt_last);
        if ((state == TGT) && cnt_last) begin
          if (row_idx == LAST_ROW) begin
            row_idx    <= '0;
            frame_done <= 1'b1;
          end else begin
            row_idx <= row_idx + 1'b1;
          end
        end
      end
    end
  end

  axis_reg_slice #(.DW(DW)) u_out_slice (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in_valid (accept),
    .in_data  (in_data),
    .in_last  (cnt_last),
    .in_user  (state == TGT),
    .load     (load),
    .m_axis   (m_axis)
  );

endmodule
